// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro sequencer: widths, control-word bit
// positions, fixed routine entry points, opcode map and sequencer states.
package micro_seq_pkg;

    localparam int AW = 8;
    localparam int CW = 32;

    localparam int INC_BIT  = 0;
    localparam int MAP_BIT  = 1;
    localparam int CLR_BIT  = 2;
    localparam int COND_BIT = 21;

    localparam logic [AW-1:0] FETCH_ADDR = 8'h00;
    localparam logic [AW-1:0] HALT_ADDR  = 8'h20;

    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_DIV    = 8'h09;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_NOT    = 8'h0C;
    localparam logic [7:0] OP_SHR    = 8'h0D;
    localparam logic [7:0] OP_SHL    = 8'h0E;

    localparam logic [AW-1:0] ENT_STORE  = 8'h04;
    localparam logic [AW-1:0] ENT_LOAD   = 8'h09;
    localparam logic [AW-1:0] ENT_ADD    = 8'h0F;
    localparam logic [AW-1:0] ENT_SUB    = 8'h15;
    localparam logic [AW-1:0] ENT_JMPGEZ = 8'h1B;
    localparam logic [AW-1:0] ENT_JMP    = 8'h1D;
    localparam logic [AW-1:0] ENT_HALT   = 8'h20;
    localparam logic [AW-1:0] ENT_MPY    = 8'h23;
    localparam logic [AW-1:0] ENT_DIV    = 8'h29;
    localparam logic [AW-1:0] ENT_AND    = 8'h2F;
    localparam logic [AW-1:0] ENT_OR     = 8'h35;
    localparam logic [AW-1:0] ENT_NOT    = 8'h3B;
    localparam logic [AW-1:0] ENT_SHR    = 8'h41;
    localparam logic [AW-1:0] ENT_SHL    = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/micro_opcode_map.sv
// Opcode-to-routine lookup: translates an IR opcode into the control-memory
// entry address of its microroutine, flagging opcodes with no routine.
module micro_opcode_map
    import micro_seq_pkg::*;
(
    input  logic [7:0]    opcode_i,
    output logic          valid_o,
    output logic [AW-1:0] entry_o
);

    // Fixed routine table; anything not listed has no microroutine
    always_comb begin
        valid_o = 1'b1;
        entry_o = FETCH_ADDR;
        case (opcode_i)
            OP_STORE:  entry_o = ENT_STORE;
            OP_LOAD:   entry_o = ENT_LOAD;
            OP_ADD:    entry_o = ENT_ADD;
            OP_SUB:    entry_o = ENT_SUB;
            OP_JMPGEZ: entry_o = ENT_JMPGEZ;
            OP_JMP:    entry_o = ENT_JMP;
            OP_HALT:   entry_o = ENT_HALT;
            OP_MPY:    entry_o = ENT_MPY;
            OP_DIV:    entry_o = ENT_DIV;
            OP_AND:    entry_o = ENT_AND;
            OP_OR:     entry_o = ENT_OR;
            OP_NOT:    entry_o = ENT_NOT;
            OP_SHR:    entry_o = ENT_SHR;
            OP_SHL:    entry_o = ENT_SHL;
            default:   valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro sequencer: control address register plus next-address selection for
// the control memory, with run/halt control, stall and error pulses.
module micro_sequencer
    import micro_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic [CW-1:0] control_signal,
    input  logic [7:0]    ir_opcode,
    input  logic          acc_ge_zero,
    output logic [AW-1:0] micro_addr,
    output logic          running,
    output logic          halted,
    output logic          instr_done,
    output logic          illegal_op,
    output logic          seq_err
);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] car_q, car_d;
    logic          running_q, halted_q;
    logic          instrDone_q, instrDone_d;
    logic          illegalOp_q, illegalOp_d;
    logic          seqErr_q, seqErr_d;
    logic          mapValid;
    logic [AW-1:0] mapEntry;
    logic [AW:0]   incSum;
    logic          unusedCtrlBits;

    // Only the sequencing bits matter here; the rest of the word drives the datapath
    assign unusedCtrlBits = ^{control_signal[CW-1:COND_BIT+1],
                              control_signal[COND_BIT-1:CLR_BIT+1]};

    micro_opcode_map uMap (
        .opcode_i (ir_opcode),
        .valid_o  (mapValid),
        .entry_o  (mapEntry)
    );

    // Next-address and next-state selection; the extra carry bit catches CAR overflow
    always_comb begin
        car_d       = car_q;
        state_d     = state_q;
        instrDone_d = 1'b0;
        illegalOp_d = 1'b0;
        seqErr_d    = 1'b0;
        incSum      = {1'b0, car_q} +
                      ((control_signal[COND_BIT] && acc_ge_zero) ? (AW+1)'(2) : (AW+1)'(1));
        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        state_d = ST_RUN;
                        car_d   = FETCH_ADDR;
                    end
                end
                ST_RUN: begin
                    if (control_signal[CLR_BIT]) begin
                        car_d       = FETCH_ADDR;
                        instrDone_d = 1'b1;
                    end else if (control_signal[MAP_BIT]) begin
                        if (mapValid) begin
                            car_d = mapEntry;
                        end else begin
                            car_d       = FETCH_ADDR;
                            illegalOp_d = 1'b1;
                        end
                    end else if (control_signal[INC_BIT]) begin
                        if (incSum[AW]) begin
                            car_d    = FETCH_ADDR;
                            seqErr_d = 1'b1;
                        end else begin
                            car_d = incSum[AW-1:0];
                        end
                    end else if (car_q != HALT_ADDR) begin
                        car_d    = FETCH_ADDR;
                        seqErr_d = 1'b1;
                    end
                    if (car_d == HALT_ADDR) begin
                        state_d = ST_HALTED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    car_d   = FETCH_ADDR;
                end
            endcase
        end
    end

    // CAR, FSM state and all status outputs advance together on one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_q       <= FETCH_ADDR;
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            instrDone_q <= 1'b0;
            illegalOp_q <= 1'b0;
            seqErr_q    <= 1'b0;
        end else begin
            car_q       <= car_d;
            state_q     <= state_d;
            running_q   <= (state_d == ST_RUN);
            halted_q    <= (state_d == ST_HALTED);
            instrDone_q <= instrDone_d;
            illegalOp_q <= illegalOp_d;
            seqErr_q    <= seqErr_d;
        end
    end

    assign micro_addr = car_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign instr_done = instrDone_q;
    assign illegal_op = illegalOp_q;
    assign seq_err    = seqErr_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: a stub control memory feeds the DUT, a
// behavioural model predicts every cycle, and a monitor scores the outputs.
module tb_micro_sequencer;

    typedef struct {
        int          target;
        logic [12:0] obs;
    } expT;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        stall;
    logic [31:0] controlSignal;
    logic [7:0]  irOpcode;
    logic        accGeZero;
    logic [7:0]  microAddr;
    logic        running;
    logic        halted;
    logic        instrDone;
    logic        illegalOp;
    logic        seqErr;

    logic [31:0] cm [0:255];
    int          mapTable [0:255];
    expT         expQ [$];
    expT         monEntry;
    int          cycleCount = 0;
    int          errors = 0;
    int          checks = 0;
    int          mCar;
    int          mState;

    micro_sequencer dut (
        .clk            (clk),
        .rst_n          (rstN),
        .start          (start),
        .stall          (stall),
        .control_signal (controlSignal),
        .ir_opcode      (irOpcode),
        .acc_ge_zero    (accGeZero),
        .micro_addr     (microAddr),
        .running        (running),
        .halted         (halted),
        .instr_done     (instrDone),
        .illegal_op     (illegalOp),
        .seq_err        (seqErr)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Stub control memory addressed by the DUT
    assign controlSignal = cm[microAddr];

    // Edge counter used to tag each prediction with the edge it belongs to
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: after each edge, pop the prediction for that edge and compare
    always @(posedge clk) begin
        #2;
        while (expQ.size() > 0 && expQ[0].target < cycleCount) begin
            checkOutput("missed_prediction", expQ[0].target, cycleCount);
            void'(expQ.pop_front());
        end
        if (expQ.size() > 0 && expQ[0].target == cycleCount) begin
            monEntry = expQ.pop_front();
            checkOutput("cycle {addr,run,halt,done,ill,err}",
                        int'({microAddr, running, halted, instrDone, illegalOp, seqErr}),
                        int'(monEntry.obs));
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void fillMapTable();
        for (int i = 0; i < 256; i++) mapTable[i] = -1;
        mapTable[8'h01] = 8'h04; mapTable[8'h02] = 8'h09; mapTable[8'h03] = 8'h0F;
        mapTable[8'h04] = 8'h15; mapTable[8'h05] = 8'h1B; mapTable[8'h06] = 8'h1D;
        mapTable[8'h07] = 8'h20; mapTable[8'h08] = 8'h23; mapTable[8'h09] = 8'h29;
        mapTable[8'h0A] = 8'h2F; mapTable[8'h0B] = 8'h35; mapTable[8'h0C] = 8'h3B;
        mapTable[8'h0D] = 8'h41; mapTable[8'h0E] = 8'h44;
    endfunction

    // Drive one cycle of inputs, predict the outcome of the coming edge, then wait for it
    task automatic applyStimulus(input bit st, input bit stl, input logic [7:0] ir, input bit acc);
        logic [31:0] w;
        int nCar, nState, n;
        bit d, il, er;
        start     = st;
        stall     = stl;
        irOpcode  = ir;
        accGeZero = acc;
        w      = cm[mCar];
        nCar   = mCar;
        nState = mState;
        d = 0; il = 0; er = 0;
        if (!stl) begin
            if (mState != 1) begin
                if (st) begin
                    if (mState == 2) nCar = 0;
                    nState = 1;
                end
            end else begin
                if (w[2]) begin
                    nCar = 0; d = 1;
                end else if (w[1]) begin
                    if (mapTable[ir] >= 0) nCar = mapTable[ir];
                    else begin nCar = 0; il = 1; end
                end else if (w[0]) begin
                    n = mCar + ((w[21] && acc) ? 2 : 1);
                    if (n > 255) begin nCar = 0; er = 1; end
                    else nCar = n;
                end else if (mCar != 32) begin
                    nCar = 0; er = 1;
                end
                if (nCar == 32) nState = 2;
            end
        end
        mCar   = nCar;
        mState = nState;
        expQ.push_back('{cycleCount + 1,
                         {8'(nCar), nState == 1, nState == 2, d, il, er}});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // From the fetch entry: three fetch microinstructions then the MAP dispatch
    task automatic runFetch(input logic [7:0] ir);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, ir, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge
    task automatic asyncReset(input string name);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput({name, "_addr"}, microAddr, 8'h00);
        checkOutput({name, "_running"}, running, 0);
        checkOutput({name, "_halted"}, halted, 0);
        expQ.delete();
        rstN   = 1'b1;
        mCar   = 0;
        mState = 0;
    endtask

    initial begin
        int r;
        logic [31:0] seqBits;
        logic [7:0]  ir;
        fillMapTable();
        for (int i = 0; i < 256; i++) cm[i] = 32'h0;
        cm[8'h00] = 32'h001; cm[8'h01] = 32'h009; cm[8'h02] = 32'h011; cm[8'h03] = 32'h002;
        for (int i = 8'h0F; i <= 8'h12; i++) cm[i] = 32'h001;
        cm[8'h13] = 32'h404;
        cm[8'h1B] = 32'h0020_0001;
        cm[8'h1C] = 32'h004;
        cm[8'h1D] = 32'h004;
        for (int i = 8'h04; i <= 8'h07; i++) cm[i] = 32'h001;
        cm[8'h08] = 32'h0;
        for (int i = 8'h44; i <= 8'hFF; i++) cm[i] = 32'h001;

        start = 0; stall = 0; irOpcode = 0; accGeZero = 0;
        mCar = 0; mState = 0;
        rstN = 1'b0;
        #12;
        checkOutput("reset_addr", microAddr, 8'h00);
        checkOutput("reset_running", running, 0);
        checkOutput("reset_halted", halted, 0);
        checkOutput("reset_pulses", {instrDone, illegalOp, seqErr}, 0);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Start and fetch/dispatch into ADD
        applyStimulus(1, 0, 8'h03, 0);
        checkOutput("start_running", running, 1);
        checkOutput("start_addr", microAddr, 8'h00);
        runFetch(8'h03);
        checkOutput("map_add_addr", microAddr, 8'h0F);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0);
        checkOutput("add_last_addr", microAddr, 8'h13);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("clr_addr", microAddr, 8'h00);
        checkOutput("clr_instr_done", instrDone, 1);

        // Stall for three cycles, including a start request that must be ignored
        applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(1, 1, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("stall_addr", microAddr, 8'h00);
        checkOutput("done_one_cycle", instrDone, 0);

        // Conditional skip taken and not taken
        runFetch(8'h05);
        checkOutput("map_jmpgez_addr", microAddr, 8'h1B);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("cond_taken_addr", microAddr, 8'h1D);
        applyStimulus(0, 0, 8'h00, 0);
        runFetch(8'h05);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("cond_not_taken_addr", microAddr, 8'h1C);
        applyStimulus(0, 0, 8'h00, 0);

        // HALT, hold, start ignored under stall, restart
        runFetch(8'h07);
        checkOutput("halt_addr", microAddr, 8'h20);
        checkOutput("halt_flag", halted, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, (i == 5), 8'h00, 0);
        applyStimulus(1, 1, 8'h00, 0);
        checkOutput("halt_hold_addr", microAddr, 8'h20);
        checkOutput("halt_hold_running", running, 0);
        applyStimulus(1, 0, 8'h00, 0);
        checkOutput("restart_addr", microAddr, 8'h00);
        checkOutput("restart_running", running, 1);

        // Unmapped opcode
        runFetch(8'hFF);
        checkOutput("illegal_addr", microAddr, 8'h00);
        checkOutput("illegal_pulse", illegalOp, 1);

        // No sequencing bit at 08
        runFetch(8'h01);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0);
        checkOutput("walk_to_08", microAddr, 8'h08);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("noseq_addr", microAddr, 8'h00);
        checkOutput("noseq_err", seqErr, 1);

        // Increment out of the top of the address space
        runFetch(8'h0E);
        for (int i = 0; i < 187; i++) applyStimulus(0, 0, 8'h00, 0);
        checkOutput("walk_to_ff", microAddr, 8'hFF);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("overflow_addr", microAddr, 8'h00);
        checkOutput("overflow_err", seqErr, 1);

        // Reset in the middle of a routine
        runFetch(8'h03);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("mid_routine_addr", microAddr, 8'h11);
        asyncReset("mid_reset");

        // Randomized phase over a random control memory
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      seqBits = 32'h4;
            else if (r < 25) seqBits = 32'h2;
            else if (r < 40) seqBits = 32'h0020_0001;
            else if (r < 90) seqBits = 32'h1;
            else             seqBits = 32'h0;
            cm[i] = ($urandom & 32'hFFDF_FFF8) | seqBits;
        end
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) ir = 8'($urandom);
            else                           ir = 8'($urandom_range(1, 14));
            applyStimulus($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                          ir, 1'($urandom_range(0, 1)));
            if (i % 1000 == 999) asyncReset("random_reset");
        end

        @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
